depth_writer: RTL and testbench

- Consumer end of the rasterizer pixel-write handshake.
- Takes pixel_info_t writes from N_PORTS rasterizers and arbitrates between them round-robin.
- Does a read-compare-write depth test against the back half of a double-buffered external synchronous frame-buffer RAM, then returns a one-cycle output_written acknowledge to the source port.
- Also performs back-buffer clears and front/back buffer swaps.

---
 rtl/depth_writer_pkg.sv | 40 ++++
 rtl/depth_writer_rr.sv | 35 +++
 rtl/depth_writer.sv | 199 +++++++++++++++++++
 tb/tb_depth_writer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/depth_writer_pkg.sv
// Shared types and constants for the depth-tested frame-buffer writer.
//   pixel_t      : {red, green, blue, depth} as stored in the frame buffer
//   pixel_info_t : {x, y, pixel} as delivered by a rasterizer
//   fb_addr_t    : {buffer bit, pixel index} for the default screen size
package depth_writer_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned COLOR_W  = 4;
  localparam int unsigned DEPTH_W  = 8;
  localparam int unsigned X_W      = 10;
  localparam int unsigned Y_W      = 9;
  localparam int unsigned ADDR_W   = $clog2(SCREEN_W * SCREEN_H);

  typedef logic [ADDR_W:0] fb_addr_t;

  localparam logic [DEPTH_W-1:0] CLEAR_DEPTH = '1;

  typedef struct packed {
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
    logic [DEPTH_W-1:0] depth;
  } pixel_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    pixel_t         pixel;
  } pixel_info_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CMP,
    ST_ACK,
    ST_CLEAR
  } state_t;

endpackage

// File: rtl/depth_writer_rr.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
//   req       : request vector
//   ptr       : highest-priority index this cycle
//   grant     : one-hot grant
//   grant_idx : index of the granted requester
//   valid     : some requester was granted
module rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             valid
);

  // Walk the ring starting at ptr; first hit wins.
  always_comb begin
    int unsigned idx;
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!valid && req[IDX_W'(idx)]) begin
        valid                = 1'b1;
        grant[IDX_W'(idx)]   = 1'b1;
        grant_idx            = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/depth_writer.sv
// Depth-tested pixel writer for a double-buffered synchronous frame buffer.
//   data_in/data_write/output_written : per-port rasterizer handshake
//   clear_req/switch_buffer           : back-buffer clear and buffer swap requests
//   clear_done, busy, front_buffer    : status
//   fb_addr/fb_re/fb_we/fb_wdata/fb_rdata : frame-buffer RAM port (1-cycle read latency)
module depth_writer #(
  parameter  int unsigned N_PORTS     = 4,
  parameter  int unsigned SCREEN_W    = depth_writer_pkg::SCREEN_W,
  parameter  int unsigned SCREEN_H    = depth_writer_pkg::SCREEN_H,
  parameter  logic [11:0] CLEAR_COLOR = 12'h000,
  localparam int unsigned ADDR_W      = $clog2(SCREEN_W * SCREEN_H)
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  depth_writer_pkg::pixel_info_t [N_PORTS-1:0] data_in,
  input  logic [N_PORTS-1:0]                        data_write,
  output logic [N_PORTS-1:0]                        output_written,
  input  logic                                      clear_req,
  input  logic                                      switch_buffer,
  output logic                                      clear_done,
  output logic                                      busy,
  output logic                                      front_buffer,
  output logic [ADDR_W:0]                           fb_addr,
  output logic                                      fb_re,
  output logic                                      fb_we,
  output depth_writer_pkg::pixel_t                  fb_wdata,
  input  depth_writer_pkg::pixel_t                  fb_rdata
);
  import depth_writer_pkg::*;

  localparam int unsigned IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned XY_W  = X_W + Y_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);
  localparam pixel_t CLEAR_PIXEL = {CLEAR_COLOR, CLEAR_DEPTH};

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_d;
  logic [N_PORTS-1:0] armed, armed_d;
  logic [XY_W-1:0]    rec_xy [N_PORTS];
  logic [XY_W-1:0]    rec_xy_d [N_PORTS];
  logic               pending_clear, pending_clear_d;
  logic               pending_switch, pending_switch_d;
  pixel_t             lat_pixel, lat_pixel_d;
  logic [N_PORTS-1:0] lat_grant, lat_grant_d;
  logic [ADDR_W-1:0]  clr_addr, clr_addr_d;

  logic [N_PORTS-1:0] output_written_d;
  logic               clear_done_d, busy_d, front_buffer_d;
  logic [ADDR_W:0]    fb_addr_d;
  logic               fb_re_d, fb_we_d;
  pixel_t             fb_wdata_d;

  logic [N_PORTS-1:0] grant_c;
  logic [IDX_W-1:0]   grant_idx_c;
  logic               grant_valid_c;
  pixel_info_t        sel_info_c;
  logic               in_range_c;
  logic [ADDR_W-1:0]  pix_addr_c;

  rr_arbiter #(.N(N_PORTS)) u_arb (
    .req       (data_write & armed),
    .ptr       (rr_ptr),
    .grant     (grant_c),
    .grant_idx (grant_idx_c),
    .valid     (grant_valid_c)
  );

  // Selected request and its back-buffer pixel index.
  assign sel_info_c = data_in[grant_idx_c];
  assign in_range_c = (32'(sel_info_c.x) < SCREEN_W) && (32'(sel_info_c.y) < SCREEN_H);
  assign pix_addr_c = ADDR_W'(ADDR_W'(sel_info_c.y) * ADDR_W'(SCREEN_W)) + ADDR_W'(sel_info_c.x);

  // Next-state and registered-output logic.
  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr;
    armed_d          = armed;
    rec_xy_d         = rec_xy;
    pending_clear_d  = pending_clear;
    pending_switch_d = pending_switch;
    lat_pixel_d      = lat_pixel;
    lat_grant_d      = lat_grant;
    clr_addr_d       = clr_addr;
    front_buffer_d   = front_buffer;
    fb_addr_d        = fb_addr;
    fb_wdata_d       = fb_wdata;
    fb_re_d          = 1'b0;
    fb_we_d          = 1'b0;
    output_written_d = '0;
    clear_done_d     = 1'b0;

    // A port re-arms once its level drops or it presents a new coordinate.
    for (int i = 0; i < N_PORTS; i++) begin
      if (!data_write[i] || ({data_in[i].x, data_in[i].y} != rec_xy[i])) begin
        armed_d[i] = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (pending_switch) begin
          front_buffer_d   = ~front_buffer;
          pending_switch_d = 1'b0;
        end else if (pending_clear) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
          fb_addr_d  = {~front_buffer, {ADDR_W{1'b0}}};
          fb_wdata_d = CLEAR_PIXEL;
          fb_we_d    = 1'b1;
        end else if (grant_valid_c) begin
          armed_d[grant_idx_c]  = 1'b0;
          rec_xy_d[grant_idx_c] = {sel_info_c.x, sel_info_c.y};
          lat_pixel_d           = sel_info_c.pixel;
          lat_grant_d           = grant_c;
          rr_ptr_d = (grant_idx_c == IDX_W'(N_PORTS - 1)) ? '0 : IDX_W'(grant_idx_c + 1'b1);
          if (in_range_c) begin
            fb_re_d   = 1'b1;
            fb_addr_d = {~front_buffer, pix_addr_c};
            state_d   = ST_READ;
          end else begin
            // Off-screen: skip the RAM, acknowledge next cycle.
            output_written_d = grant_c;
            state_d          = ST_ACK;
          end
        end
      end
      ST_READ: state_d = ST_CMP;
      ST_CMP: begin
        if (lat_pixel.depth < fb_rdata.depth) begin
          fb_we_d    = 1'b1;
          fb_wdata_d = lat_pixel;
        end
        output_written_d = lat_grant;
        state_d          = ST_ACK;
      end
      ST_ACK: state_d = ST_IDLE;
      ST_CLEAR: begin
        if (clr_addr == LAST_ADDR) begin
          clear_done_d    = 1'b1;
          pending_clear_d = 1'b0;
          state_d         = ST_IDLE;
        end else begin
          clr_addr_d = clr_addr + 1'b1;
          fb_addr_d  = {~front_buffer, clr_addr + 1'b1};
          fb_we_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // New requests override any same-cycle service so none is lost.
    if (clear_req)     pending_clear_d  = 1'b1;
    if (switch_buffer) pending_switch_d = 1'b1;

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      rr_ptr         <= '0;
      armed          <= '1;
      for (int i = 0; i < N_PORTS; i++) rec_xy[i] <= '0;
      pending_clear  <= 1'b0;
      pending_switch <= 1'b0;
      lat_pixel      <= '0;
      lat_grant      <= '0;
      clr_addr       <= '0;
      output_written <= '0;
      clear_done     <= 1'b0;
      busy           <= 1'b0;
      front_buffer   <= 1'b0;
      fb_addr        <= '0;
      fb_re          <= 1'b0;
      fb_we          <= 1'b0;
      fb_wdata       <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr         <= rr_ptr_d;
      armed          <= armed_d;
      rec_xy         <= rec_xy_d;
      pending_clear  <= pending_clear_d;
      pending_switch <= pending_switch_d;
      lat_pixel      <= lat_pixel_d;
      lat_grant      <= lat_grant_d;
      clr_addr       <= clr_addr_d;
      output_written <= output_written_d;
      clear_done     <= clear_done_d;
      busy           <= busy_d;
      front_buffer   <= front_buffer_d;
      fb_addr        <= fb_addr_d;
      fb_re          <= fb_re_d;
      fb_we          <= fb_we_d;
      fb_wdata       <= fb_wdata_d;
    end
  end

endmodule

// File: tb/tb_depth_writer.sv
// Directed bench for depth_writer: full-size instance with a RAM model, plus a
// small-screen instance used for the clear/swap sequence.
module tb_depth_writer;
  import depth_writer_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Full-size instance
  pixel_info_t [3:0] din;
  logic [3:0]  dw, ow;
  logic        clr, sw, cdone, busy, front, fb_re, fb_we;
  logic [19:0] fb_addr;
  pixel_t      fb_wdata;
  pixel_t      fb_rdata = '0;

  depth_writer dut (
    .clock(clock), .reset(reset), .data_in(din), .data_write(dw),
    .output_written(ow), .clear_req(clr), .switch_buffer(sw),
    .clear_done(cdone), .busy(busy), .front_buffer(front),
    .fb_addr(fb_addr), .fb_re(fb_re), .fb_we(fb_we),
    .fb_wdata(fb_wdata), .fb_rdata(fb_rdata)
  );

  // Small 8x4 instance, RAM always returns depth 255
  pixel_info_t [1:0] din_s;
  logic [1:0]  dw_s, ow_s;
  logic        clr_s, sw_s, cdone_s, busy_s, front_s, fb_re_s, fb_we_s;
  logic [5:0]  fb_addr_s;
  pixel_t      fb_wdata_s;
  pixel_t      fb_rdata_s;
  assign fb_rdata_s = 20'hFFFFF;

  depth_writer #(.N_PORTS(2), .SCREEN_W(8), .SCREEN_H(4)) dut_s (
    .clock(clock), .reset(reset), .data_in(din_s), .data_write(dw_s),
    .output_written(ow_s), .clear_req(clr_s), .switch_buffer(sw_s),
    .clear_done(cdone_s), .busy(busy_s), .front_buffer(front_s),
    .fb_addr(fb_addr_s), .fb_re(fb_re_s), .fb_we(fb_we_s),
    .fb_wdata(fb_wdata_s), .fb_rdata(fb_rdata_s)
  );

  // Synchronous RAM model; unwritten locations hold depth all-ones
  logic [19:0] mem [int];
  always @(posedge clock) begin
    if (fb_re) fb_rdata <= mem.exists(int'(fb_addr)) ? mem[int'(fb_addr)] : 20'hFFFFF;
    if (fb_we) mem[int'(fb_addr)] = fb_wdata;
  end

  typedef struct { int cyc; logic [3:0] ports; } ack_t;
  typedef struct { int cyc; int addr; logic [19:0] data; } wr_t;
  ack_t ack_q[$];
  wr_t  wr_q[$];
  ack_t ack_s_q[$];
  wr_t  wr_s_q[$];
  int   done_s_q[$];
  int   rd_cnt = 0;
  int   front_rise_s = -1;

  // Mid-cycle event recorder
  always @(negedge clock) begin
    if (ow != 4'b0) ack_q.push_back('{cyc, ow});
    if (fb_we)      wr_q.push_back('{cyc, int'(fb_addr), fb_wdata});
    if (fb_re)      rd_cnt++;
    if (ow_s != 2'b0) ack_s_q.push_back('{cyc, {2'b00, ow_s}});
    if (fb_we_s)      wr_s_q.push_back('{cyc, int'(fb_addr_s), fb_wdata_s});
    if (cdone_s)      done_s_q.push_back(cyc);
    if (front_s && front_rise_s < 0) front_rise_s = cyc;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    ack_q.delete();
    wr_q.delete();
    rd_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  function automatic pixel_info_t mk(input int x, input int y, input logic [19:0] pix);
    pixel_info_t p;
    p.x     = 10'(x);
    p.y     = 9'(y);
    p.pixel = pix;
    return p;
  endfunction

  int n, m, bad;

  initial begin
    din = '0; dw = '0; clr = 1'b0; sw = 1'b0;
    din_s = '0; dw_s = '0; clr_s = 1'b0; sw_s = 1'b0;

    // Reset state
    tick(2);
    check("rst_ow", ow, 4'b0);
    check("rst_fb_re", fb_re, 1'b0);
    check("rst_fb_we", fb_we, 1'b0);
    check("rst_fb_addr", fb_addr, 20'h0);
    check("rst_fb_wdata", fb_wdata, 20'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_clear_done", cdone, 1'b0);
    check("rst_front", front, 1'b0);
    reset = 1'b0;
    tick(1);

    // Single port, depth pass: stored 200 at (10,5), incoming 50
    mem[(1 << 19) + 3210] = 20'h000C8;
    clear_logs();
    din[0] = mk(10, 5, 20'h12332);
    dw = 4'b0001;
    n = cyc;
    tick(1);
    check("single_fb_re", fb_re, 1'b1);
    check("single_fb_addr", fb_addr, 20'd527498);
    check("single_busy", busy, 1'b1);
    tick(1);
    check("single_fb_re_drop", fb_re, 1'b0);
    tick(1);
    check("single_fb_we", fb_we, 1'b1);
    check("single_fb_wdata", fb_wdata, 20'h12332);
    check("single_ack", ow, 4'b0001);
    check("single_latency", cyc - n, 3);
    tick(1);
    check("single_ack_drop", ow, 4'b0000);
    check("single_we_drop", fb_we, 1'b0);

    // Held level, unchanged coordinate: no further ack
    tick(20);
    check("held_acks", ack_q.size(), 1);
    check("held_writes", wr_q.size(), 1);

    // New x re-arms the port
    clear_logs();
    din[0].x = 10'd11;
    tick(6);
    check("rearm_acks", ack_q.size(), 1);
    check("rearm_wr_cnt", wr_q.size(), 1);
    check("rearm_wr_addr", (wr_q.size() > 0) ? wr_q[0].addr : -1, (1 << 19) + 3211);

    // Depth fail: (10,5) now holds depth 50, incoming 50
    clear_logs();
    din[0].x = 10'd10;
    tick(8);
    check("dfail_no_we", wr_q.size(), 0);
    check("dfail_acks", ack_q.size(), 1);
    check("dfail_ack_port", (ack_q.size() > 0) ? ack_q[0].ports : 4'hF, 4'b0001);
    check("dfail_reads", rd_cnt, 1);
    dw = 4'b0;
    tick(2);

    // Round-robin from pointer 0; port 0 re-requests mid-sequence
    do_reset();
    clear_logs();
    din[0] = mk(1, 0, 20'h11110);
    din[1] = mk(2, 0, 20'h22210);
    din[2] = mk(3, 0, 20'h33310);
    dw = 4'b0111;
    n = cyc;
    tick(4);
    din[0].x = 10'd4;
    tick(14);
    check("rr_ack_cnt", ack_q.size(), 4);
    if (ack_q.size() == 4) begin
      check("rr_order0", ack_q[0].ports, 4'b0001);
      check("rr_order1", ack_q[1].ports, 4'b0010);
      check("rr_order2", ack_q[2].ports, 4'b0100);
      check("rr_order3", ack_q[3].ports, 4'b0001);
      check("rr_cyc0", ack_q[0].cyc - n, 3);
      check("rr_cyc1", ack_q[1].cyc - n, 7);
      check("rr_cyc2", ack_q[2].cyc - n, 11);
      check("rr_cyc3", ack_q[3].cyc - n, 15);
    end
    dw = 4'b0;
    tick(2);

    // Off-screen coordinate: ack next cycle, no RAM access
    clear_logs();
    din[3] = mk(700, 0, 20'h44410);
    dw = 4'b1000;
    n = cyc;
    tick(3);
    check("oor_acks", ack_q.size(), 1);
    check("oor_port", (ack_q.size() > 0) ? ack_q[0].ports : 4'hF, 4'b1000);
    check("oor_latency", (ack_q.size() > 0) ? ack_q[0].cyc - n : -1, 1);
    check("oor_no_read", rd_cnt, 0);
    check("oor_no_write", wr_q.size(), 0);
    dw = 4'b0;
    tick(2);

    // Reset during CMP abandons the transaction; request replays after release
    clear_logs();
    din[1] = mk(5, 0, 20'h55510);
    dw = 4'b0010;
    tick(2);
    check("mid_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_we", fb_we, 1'b0);
    check("mid_rst_ow", ow, 4'b0);
    check("mid_rst_busy", busy, 1'b0);
    tick(2);
    check("mid_rst_no_ack", ack_q.size(), 0);
    reset = 1'b0;
    tick(8);
    check("mid_replay_acks", ack_q.size(), 1);
    check("mid_replay_port", (ack_q.size() > 0) ? ack_q[0].ports : 4'hF, 4'b0010);
    check("mid_replay_wr", wr_q.size(), 1);
    dw = 4'b0;
    tick(2);

    // Small screen: clear requested mid-transaction, swap requested mid-clear
    din_s[0] = mk(2, 1, 20'hABC10);
    dw_s = 2'b01;
    n = cyc;
    tick(1);
    clr_s = 1'b1;
    tick(1);
    clr_s = 1'b0;
    tick(4);
    sw_s = 1'b1;
    dw_s = 2'b00;
    tick(1);
    sw_s = 1'b0;
    tick(40);
    check("clr_ack_cnt", ack_s_q.size(), 1);
    check("clr_ack_cyc", (ack_s_q.size() > 0) ? ack_s_q[0].cyc - n : -1, 3);
    check("clr_wr_cnt", wr_s_q.size(), 33);
    if (wr_s_q.size() == 33) begin
      check("clr_txn_addr", wr_s_q[0].addr, 42);
      check("clr_txn_data", wr_s_q[0].data, 20'hABC10);
      bad = 0;
      for (int i = 0; i < 32; i++) begin
        if (wr_s_q[i+1].addr != 32 + i || wr_s_q[i+1].data != 20'h000FF ||
            wr_s_q[i+1].cyc != n + 5 + i) bad++;
      end
      check("clr_seq_bad", bad, 0);
    end
    check("clr_done_cnt", done_s_q.size(), 1);
    check("clr_done_cyc", (done_s_q.size() > 0) ? done_s_q[0] - n : -1, 37);
    check("swap_rise_cyc", front_rise_s - n, 38);
    check("swap_front", front_s, 1'b1);

    // After the swap the back buffer is 0
    din_s[0] = mk(1, 1, 20'h12340);
    dw_s = 2'b01;
    tick(1);
    check("swap_back_re", fb_re_s, 1'b1);
    check("swap_back_addr", fb_addr_s, 6'd9);
    tick(5);
    dw_s = 2'b00;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
